// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, coin unit values and the
// change-dispenser state encoding.
package vm_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    C5   = 2'b10,
    C10  = 2'b11
  } coin_t;

  localparam int UNIT5  = 5;
  localparam int UNIT10 = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    FIRE   = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4,
    JAM    = 3'd5
  } state_t;

  // Number of 5-unit steps a given coin pays off.
  function automatic logic [2:0] coin_steps(coin_t c);
    case (c)
      C10:     return 3'(UNIT10 / UNIT5);
      C5:      return 3'(UNIT5 / UNIT5);
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/strobe/status bundle between the vending controller and the change
// dispenser; clk and rst stay outside as plain ports.
interface change_dispenser_if #(parameter int CNT_W = 6);
  logic             req;
  logic [2:0]       amount;
  logic             refill5;
  logic             refill10;
  logic             coin_drop;
  logic             fire5;
  logic             fire10;
  logic             busy;
  logic             done;
  logic             short;
  logic             jam;
  logic [CNT_W-1:0] cnt5;
  logic [CNT_W-1:0] cnt10;
  logic [2:0]       owed;

  modport master (
    output req, amount, refill5, refill10, coin_drop,
    input  fire5, fire10, busy, done, short, jam, cnt5, cnt10, owed
  );

  modport slave (
    input  req, amount, refill5, refill10, coin_drop,
    output fire5, fire10, busy, done, short, jam, cnt5, cnt10, owed
  );
endinterface

// File: rtl/hopper_counter.sv
// Saturating up/down coin inventory for one hopper; a simultaneous load and
// eject cancel out.
module hopper_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != MAX) count <= count + ONE;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - ONE;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays an owed amount greedily from a 10-unit and a 5-unit
// hopper, confirming each coin with a drop sensor and latching a jam on timeout.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  change_dispenser_if.slave bus
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // The strobe cycle counts as the first elapsed cycle, so WAIT gives up
  // after TIMEOUT-1 cycles and jam shows exactly TIMEOUT cycles after fire.
  localparam logic [TMR_W-1:0] JAM_AT  = TMR_W'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  state_t           state, state_nxt;
  coin_t            coin, coin_nxt;
  logic [2:0]       owed, owed_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             dec5, dec10;
  logic [CNT_W-1:0] cnt5, cnt10;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      coin  <= NONE;
      owed  <= '0;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      coin  <= coin_nxt;
      owed  <= owed_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    state_nxt = state;
    coin_nxt  = coin;
    owed_nxt  = owed;
    tmr_nxt   = tmr;
    dec5      = 1'b0;
    dec10     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          owed_nxt  = bus.amount;
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        if (owed >= 3'd2 && cnt10 != '0) begin
          coin_nxt  = C10;
          state_nxt = FIRE;
        end else if (owed >= 3'd1 && cnt5 != '0) begin
          coin_nxt  = C5;
          state_nxt = FIRE;
        end else begin
          coin_nxt  = NONE;
          state_nxt = DONE;
        end
      end
      FIRE: begin
        tmr_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.coin_drop) begin
          owed_nxt  = owed - coin_steps(coin);
          dec5      = (coin == C5);
          dec10     = (coin == C10);
          state_nxt = SELECT;
        end else if (tmr == JAM_AT) begin
          state_nxt = JAM;
        end else begin
          tmr_nxt = tmr + TMR_ONE;
        end
      end
      DONE:    state_nxt = IDLE;
      JAM:     state_nxt = JAM;
      default: state_nxt = IDLE;
    endcase
  end

  hopper_counter #(.W(CNT_W)) u_hopper5 (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.refill5),
    .dec   (dec5),
    .count (cnt5)
  );

  hopper_counter #(.W(CNT_W)) u_hopper10 (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.refill10),
    .dec   (dec10),
    .count (cnt10)
  );

  // Strobes and status decode straight from registered state, so reset kills them at once.
  assign bus.fire5  = (state == FIRE) && (coin == C5);
  assign bus.fire10 = (state == FIRE) && (coin == C10);
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.short  = (state == DONE) && (owed != 3'd0);
  assign bus.jam    = (state == JAM);
  assign bus.owed   = owed;
  assign bus.cnt5   = cnt5;
  assign bus.cnt10  = cnt10;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter CNT_W, default 6: width of each hopper inventory counter.
REQ-002 SHALL have parameter TIMEOUT, default 15: cycles waited for a coin-drop sensor pulse before declaring a jam.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  change request, sampled only in IDLE.
REQ-006 SHALL have port amount  input  3  change owed in 5-unit steps (0..7 = 0..35), sampled with req.
REQ-007 SHALL have ports refill5 and refill10  input  1 each  one coin loaded into the 5-unit or 10-unit hopper, per cycle high.
REQ-008 SHALL have port coin_drop  input  1  sensor pulse confirming the fired coin left the hopper.
REQ-009 SHALL have ports fire5 and fire10  output  1 each  one-cycle hopper eject strobes.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have ports done and short  output  1 each  done pulses one cycle at completion; short is valid with done and means not all change was paid.
REQ-012 SHALL have port jam  output  1  sticky hopper-fault flag.
REQ-013 SHALL have ports cnt5 and cnt10  output  CNT_W each  current hopper inventories.
REQ-014 SHALL have port owed  output  3  5-unit steps still owed.

Function
REQ-015 SHALL implement states IDLE, SELECT, FIRE, WAIT, DONE, JAM.
REQ-016 IDLE: on req=1, SHALL latch amount into owed and go to SELECT; busy rises the following cycle.
REQ-017 SELECT: SHALL go to FIRE with the 10-unit coin if owed>=2 and cnt10>0; else FIRE with the 5-unit coin if owed>=1 and cnt5>0; else go to DONE.
REQ-018 An amount of 0 SHALL pass through SELECT to DONE with short=0 and no strobes.
REQ-019 FIRE: SHALL assert exactly one of fire5/fire10 for one cycle, load the timeout counter with 0, and go to WAIT.
REQ-020 WAIT: on coin_drop, SHALL decrement owed by 2 (10-unit coin) or 1 (5-unit coin), decrement the matching inventory, and return to SELECT.
REQ-021 WAIT: if TIMEOUT cycles elapse without coin_drop, SHALL go to JAM with owed and the inventories unchanged.
REQ-022 DONE: SHALL pulse done for one cycle, set short=1 iff owed!=0, and return to IDLE.
REQ-023 JAM: SHALL hold jam=1 and busy=1, ignore req and coin_drop, and leave only by reset.
REQ-024 req outside IDLE and coin_drop outside WAIT SHALL be ignored.
REQ-025 Latency: req at cycle N SHALL yield the first fire strobe at cycle N+2 when an inventory suffices.
REQ-026 Refill SHALL increment the inventory at any state and saturate at 2^CNT_W-1.
REQ-027 A refill and a dispense decrement of the same hopper in the same cycle SHALL leave that count unchanged.
REQ-028 Inventory SHALL never decrement below 0; SELECT never fires an empty hopper.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, with owed=0, cnt5=cnt10=0, fire5=fire10=0, busy=0, done=0, short=0, and jam=0.
REQ-030 Reset asserted mid-dispense SHALL abort the operation without any further strobe.

Structure
REQ-031 The shared package vm_pkg SHALL hold the coin codes (NONE=2'b00, C5=2'b10, C10=2'b11), the unit values (5, 10), and the dispenser state encoding.
REQ-032 A sub-module hopper_counter SHALL implement the saturating up/down inventory counter; it is instantiated twice.

Verification
REQ-033 Refill 3x10 and 3x5; req with amount=3; drop each coin 2 cycles after its strobe -> one fire10, then one fire5, then done=1, short=0, cnt10=2, cnt5=2.
REQ-034 cnt10=0, cnt5=1, amount=3 -> one fire5, then done=1, short=1, owed=2.
REQ-035 Fire with coin_drop never asserted -> jam=1 exactly TIMEOUT cycles after the strobe; later req is ignored; rst low clears all state.
REQ-036 Refill10 asserted in the same cycle as the 10-unit coin_drop -> cnt10 unchanged; cnt5 at its maximum plus refill5 -> stays at 63.
REQ-037 amount=0 -> done and short=0 two cycles after req with no strobes; req during busy and a stray coin_drop in IDLE -> no effect.
